// File: rtl/word_fifo.sv
// word_fifo: synchronous FIFO with a registered output word feeding the Word register stage.
// Optional build macro WORD_FIFO_OVERFLOW_EN adds sticky overflow/underflow flags.
module word_fifo #(
  parameter int unsigned     Width     = 8,
  parameter int unsigned     Depth     = 8,
  parameter int unsigned     AddrWidth = 3,
  parameter logic [Width-1:0] RST      = {Width{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [Width-1:0]     D,
  input  logic                 re,
  output logic [Width-1:0]     Q,
  output logic                 valid,
  output logic                 full,
  output logic                 empty,
  output logic [AddrWidth:0]   count
`ifdef WORD_FIFO_OVERFLOW_EN
  ,
  output logic                 overflow,
  output logic                 underflow
`endif
);

  localparam logic [AddrWidth:0] FullCount = (AddrWidth+1)'(Depth);

  logic [Width-1:0]     mem [Depth];
  logic [AddrWidth-1:0] wr_ptr;
  logic [AddrWidth-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Flags come only from the registered count, never from we/re.
  assign full  = (count == FullCount);
  assign empty = (count == '0);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside a pop.
  assign do_pop  = re && !empty;
  assign do_push = we && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      Q      <= RST;
      valid  <= 1'b0;
    end else begin
      valid <= do_pop;
      if (do_push) begin
        wr_ptr <= wr_ptr + AddrWidth'(1);
      end
      if (do_pop) begin
        Q      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AddrWidth'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AddrWidth+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AddrWidth+1)'(1);
      end
    end
  end

`ifdef WORD_FIFO_OVERFLOW_EN
  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we && full && !re) begin
        overflow <= 1'b1;
      end
      if (re && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_word_fifo.sv
// tb_word_fifo: scoreboard-driven self-checking bench for word_fifo.
// Honours WORD_FIFO_OVERFLOW_EN to also check the sticky error flags.
module tb_word_fifo;

  logic       clk;
  logic       rst;
  logic       we;
  logic [7:0] D;
  logic       re;
  logic [7:0] Q;
  logic       valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
`ifdef WORD_FIFO_OVERFLOW_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks;
  int failures;

  logic [7:0] sb[$];
  logic [7:0] expQ;
  logic       expOverflow;
  logic       expUnderflow;

  word_fifo dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .D(D),
    .re(re),
    .Q(Q),
    .valid(valid),
    .full(full),
    .empty(empty),
    .count(count)
`ifdef WORD_FIFO_OVERFLOW_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h required=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkFlags(input string tag);
`ifdef WORD_FIFO_OVERFLOW_EN
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(expOverflow));
    checkOutput({tag, "_underflow"}, 32'(underflow), 32'(expUnderflow));
`else
    checkOutput({tag, "_nflags"}, 32'(expOverflow) & 32'(0), 32'(0) & 32'(expUnderflow) | 32'(count) & 32'(0));
`endif
  endtask

  // One clock of stimulus; the scoreboard predicts acceptance and the popped word.
  task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input string tag);
    logic acceptPop;
    logic acceptPush;
    we = w;
    D  = d;
    re = r;
    acceptPop  = r && (sb.size() > 0);
    acceptPush = w && ((sb.size() < 8) || acceptPop);
    if (w && sb.size() == 8 && !r) expOverflow = 1'b1;
    if (r && sb.size() == 0) expUnderflow = 1'b1;
    if (acceptPop) expQ = sb.pop_front();
    if (acceptPush) sb.push_back(d);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, 32'(valid), 32'(acceptPop));
    checkOutput({tag, "_q"}, 32'(Q), 32'(expQ));
    checkOutput({tag, "_count"}, 32'(count), 32'(sb.size()));
    checkOutput({tag, "_full"}, 32'(full), 32'(sb.size() == 8));
    checkOutput({tag, "_empty"}, 32'(empty), 32'(sb.size() == 0));
    we = 1'b0;
    re = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    expQ         = 8'h00;
    expOverflow  = 1'b0;
    expUnderflow = 1'b0;
    rst = 1'b0;
    we  = 1'b0;
    re  = 1'b0;
    D   = 8'h00;

    // Held in reset while a push is requested: nothing may change.
    for (int i = 0; i < 4; i++) begin
      we = ~we;
      D  = 8'hA5;
      @(posedge clk);
      #1;
      checkOutput("rst_q", 32'(Q), 32'h00);
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_valid", 32'(valid), 32'd0);
    end
    we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkFlags("rst");

    // Fill, overflow attempt, drain, underflow attempt.
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 8'(i), 1'b0, "fill");
    applyStimulus(1'b1, 8'hFF, 1'b0, "ovf");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, "drain");
    applyStimulus(1'b0, 8'h00, 1'b1, "udf");
    checkOutput("udf_hold", 32'(Q), 32'h08);
    checkFlags("err");

    // Simultaneous push/pop at a middling count.
    applyStimulus(1'b1, 8'h11, 1'b0, "mid");
    applyStimulus(1'b1, 8'h12, 1'b0, "mid");
    applyStimulus(1'b1, 8'h13, 1'b0, "mid");
    applyStimulus(1'b1, 8'h3C, 1'b1, "mid_both");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1, "mid_drain");

    // Simultaneous push/pop when empty: push only.
    applyStimulus(1'b1, 8'h44, 1'b1, "empty_both");
    applyStimulus(1'b0, 8'h00, 1'b1, "empty_drain");

    // Simultaneous push/pop when full.
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, "fill2");
    applyStimulus(1'b1, 8'h99, 1'b1, "full_both");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 1'b1, "drain2");

    // Interleaved traffic to wrap the pointers several times.
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h20 + i), (i % 3) != 0, "wrap");
    while (sb.size() > 0) applyStimulus(1'b0, 8'h00, 1'b1, "wrap_drain");
    checkFlags("pre_reset");

    // Asynchronous reset between edges with data pending.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, "pre");
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_empty", 32'(empty), 32'd1);
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_q", 32'(Q), 32'h00);
    checkOutput("mid_rst_full", 32'(full), 32'd0);
    sb.delete();
    expQ         = 8'h00;
    expOverflow  = 1'b0;
    expUnderflow = 1'b0;
    checkFlags("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h5A, 1'b0, "post");
    applyStimulus(1'b1, 8'h5B, 1'b0, "post");
    applyStimulus(1'b0, 8'h00, 1'b1, "post_pop");
    checkOutput("post_first", 32'(Q), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
